// File: rtl/keystream_xor_cipher_pkg.sv
// Shared types and sizing helpers for the keystream cipher path.
package keystream_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] ks_byte_t;

  localparam int KS_FIFO_DEPTH_DEF = 4;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int KS_LEVEL_W = level_w(KS_FIFO_DEPTH_DEF);

endpackage

// File: rtl/keystream_xor_cipher_if.sv
// Keystream input, plaintext/ciphertext handshakes and status of the cipher.
interface keystream_xor_cipher_if
  import keystream_pkg::*;
#(
  parameter int LEVEL_W = KS_LEVEL_W
);
  logic               i_ks_bit;
  logic               i_ks_valid;
  logic               i_resync;
  ks_byte_t           i_data;
  logic               i_data_valid;
  logic               o_data_ready;
  ks_byte_t           o_data;
  logic               o_data_valid;
  logic               i_data_ready;
  logic [LEVEL_W-1:0] o_ks_level;
  logic               o_ks_overflow;

  modport slave (
    input  i_ks_bit, i_ks_valid, i_resync, i_data, i_data_valid, i_data_ready,
    output o_data_ready, o_data, o_data_valid, o_ks_level, o_ks_overflow
  );

  modport master (
    output i_ks_bit, i_ks_valid, i_resync, i_data, i_data_valid, i_data_ready,
    input  o_data_ready, o_data, o_data_valid, o_ks_level, o_ks_overflow
  );
endinterface

// File: rtl/keystream_byte_fifo.sv
// Key-byte FIFO; simultaneous push and pop are honoured even when full.
module keystream_byte_fifo
  import keystream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  ks_byte_t                  din,
  input  logic                      pop,
  output ks_byte_t                  dout,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  ks_byte_t        mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When full, wr_ptr aliases rd_ptr; the head is read before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/keystream_xor_cipher.sv
// Packs serial keystream bits into key bytes and XORs them onto plaintext bytes.
module keystream_xor_cipher
  import keystream_pkg::*;
#(
  parameter int KS_FIFO_DEPTH = 4
) (
  input logic                    i_clk,
  input logic                    i_rst,
  keystream_xor_cipher_if.slave  bus
);
  logic [6:0] sr;
  logic [2:0] cnt;
  logic       byte_done;
  ks_byte_t   new_byte;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  ks_byte_t   head;
  ks_byte_t   data_q;
  logic       valid_q;
  logic       ovf_q;
  logic       ready;

  assign byte_done = bus.i_ks_valid && !bus.i_resync && (cnt == 3'd7);
  assign new_byte  = {sr, bus.i_ks_bit};
  assign ready     = !bus.i_resync && !fifo_empty && (!valid_q || bus.i_data_ready);
  assign pop       = bus.i_data_valid && ready;
  // Space is judged after this cycle's pop, so a full FIFO still accepts when draining.
  assign push      = byte_done && (!fifo_full || pop);

  keystream_byte_fifo #(.DEPTH(KS_FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (bus.i_resync),
    .push  (push),
    .din   (new_byte),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.o_ks_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr      <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.i_resync) begin
      sr      <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (bus.i_ks_valid) begin
        sr  <= {sr[5:0], bus.i_ks_bit};
        cnt <= cnt + 3'd1;
      end
      if (byte_done && !push) ovf_q <= 1'b1;
      if (pop) begin
        data_q  <= bus.i_data ^ head;
        valid_q <= 1'b1;
      end else if (bus.i_data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_data_ready  = ready;
  assign bus.o_data        = data_q;
  assign bus.o_data_valid  = valid_q;
  assign bus.o_ks_overflow = ovf_q;
endmodule

// File: tb/tb_keystream_xor_cipher.sv
// Directed bench for keystream_xor_cipher with a queue-based reference model.
module tb_keystream_xor_cipher;
  import keystream_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keystream_xor_cipher_if #(.LEVEL_W(3)) bus ();

  keystream_xor_cipher #(.KS_FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 0;

  logic [7:0] m_q[$];
  int         m_nbits = 0;
  logic [7:0] m_acc   = '0;
  bit         m_vld   = 0;
  bit         m_ovf   = 0;
  logic [7:0] m_dat   = '0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit exp_rdy;
    exp_rdy = !bus.i_resync && (m_q.size() != 0) && (!m_vld || bus.i_data_ready);
    check8("level",    8'(bus.o_ks_level), 8'(m_q.size()));
    check8("overflow", 8'(bus.o_ks_overflow), 8'(m_ovf));
    check8("valid",    8'(bus.o_data_valid), 8'(m_vld));
    check8("ready",    8'(bus.o_data_ready), 8'(exp_rdy));
    check8("data",     bus.o_data, m_dat);
  endtask

  // Reference behaviour: whole bytes in a queue, bits accumulated arithmetically.
  task automatic model_step();
    bit         rdy;
    bit         hs;
    logic [7:0] hd;
    if (rst) begin
      m_q.delete(); m_nbits = 0; m_acc = '0; m_vld = 0; m_ovf = 0; m_dat = '0;
    end else if (bus.i_resync) begin
      m_q.delete(); m_nbits = 0; m_acc = '0; m_vld = 0; m_ovf = 0;
    end else begin
      rdy = (m_q.size() != 0) && (!m_vld || bus.i_data_ready);
      hs  = bus.i_data_valid && rdy;
      hd  = '0;
      if (hs) hd = m_q.pop_front();
      if (bus.i_ks_valid) begin
        m_acc = {m_acc[6:0], bus.i_ks_bit};
        m_nbits++;
        if (m_nbits == 8) begin
          m_nbits = 0;
          if (m_q.size() < DEPTH) m_q.push_back(m_acc);
          else m_ovf = 1;
        end
      end
      if (hs) begin
        m_dat = bus.i_data ^ hd;
        m_vld = 1;
      end else if (bus.i_data_ready) begin
        m_vld = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    if (cmp_en) compare_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
    rst              = 1'b0;
    bus.i_ks_valid   = 1'b0;
    bus.i_resync     = 1'b0;
    bus.i_data_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.i_ks_valid = 1'b1;
    bus.i_ks_bit   = b;
    tick();
    repeat (gap) tick();
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_pt(input logic [7:0] d);
    bus.i_data_valid = 1'b1;
    bus.i_data       = d;
    tick();
  endtask

  task automatic pulse_resync();
    bus.i_resync = 1'b1;
    tick();
  endtask

  initial begin
    bus.i_ks_bit     = 1'b0;
    bus.i_ks_valid   = 1'b0;
    bus.i_resync     = 1'b0;
    bus.i_data       = '0;
    bus.i_data_valid = 1'b0;
    bus.i_data_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    cmp_en = 1;
    check8("rst_data",  bus.o_data, 8'h00);
    check8("rst_level", 8'(bus.o_ks_level), 8'd0);

    // Basic encrypt: key 0xB2, plaintext 0x41
    send_byte(8'hB2, 7);
    check8("basic_level1", 8'(bus.o_ks_level), 8'd1);
    send_pt(8'h41);
    check8("basic_ct", bus.o_data, 8'hF3);
    check8("basic_level0", 8'(bus.o_ks_level), 8'd0);
    tick();

    // Overflow: five bytes into a four-deep queue
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 0);
    check8("ovf_level", 8'(bus.o_ks_level), 8'd4);
    check8("ovf_flag",  8'(bus.o_ks_overflow), 8'd1);
    for (int b = 1; b <= 4; b++) begin
      send_pt(8'h00);
      check8("ovf_ct", bus.o_data, 8'(b));
    end
    tick();
    check8("ovf_sticky", 8'(bus.o_ks_overflow), 8'd1);

    // Backpressure
    pulse_resync();
    check8("resync_ovf_clr", 8'(bus.o_ks_overflow), 8'd0);
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    bus.i_data_ready = 1'b0;
    send_pt(8'h11);
    check8("bp_ct0", bus.o_data, 8'hB4);
    for (int k = 0; k < 3; k++) begin
      send_pt(8'h22);
      check8("bp_hold", bus.o_data, 8'hB4);
      check8("bp_level", 8'(bus.o_ks_level), 8'd1);
    end
    bus.i_data_ready = 1'b1;
    send_pt(8'h22);
    check8("bp_ct1", bus.o_data, 8'h1E);
    tick();

    // Full queue: 8th strobe coincides with a pop
    pulse_resync();
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    send_byte(8'h40, 0);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h50 >> i), 0);
    bus.i_ks_valid   = 1'b1;
    bus.i_ks_bit     = 1'b0;
    bus.i_data_valid = 1'b1;
    bus.i_data       = 8'h00;
    tick();
    check8("full_ct", bus.o_data, 8'h10);
    check8("full_level", 8'(bus.o_ks_level), 8'd4);
    check8("full_ovf", 8'(bus.o_ks_overflow), 8'd0);
    for (int b = 2; b <= 5; b++) begin
      send_pt(8'h00);
      check8("full_order", bus.o_data, 8'(b << 4));
    end
    tick();

    // Resync mid-byte, with a strobe in the resync cycle
    send_byte(8'h00, 0);  // leaves a complete byte queued so the flush is visible
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 0);
    bus.i_ks_valid = 1'b1;
    bus.i_ks_bit   = 1'b0;
    pulse_resync();
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    check8("rs_level", 8'(bus.o_ks_level), 8'd1);
    check8("rs_ovf", 8'(bus.o_ks_overflow), 8'd0);
    send_pt(8'h0F);
    check8("rs_ct", bus.o_data, 8'hF0);
    tick();

    // Reset with valid ciphertext and three bytes queued
    send_byte(8'h5A, 0);
    send_byte(8'h6B, 0);
    send_byte(8'h7C, 0);
    send_byte(8'h8D, 0);
    bus.i_data_ready = 1'b0;
    send_pt(8'hFF);
    check8("pre_rst_valid", 8'(bus.o_data_valid), 8'd1);
    check8("pre_rst_level", 8'(bus.o_ks_level), 8'd3);
    rst = 1'b1;
    tick();
    check8("post_rst_data",  bus.o_data, 8'h00);
    check8("post_rst_valid", 8'(bus.o_data_valid), 8'd0);
    check8("post_rst_level", 8'(bus.o_ks_level), 8'd0);
    bus.i_data_ready = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/keystream_xor_cipher.md
# keystream_xor_cipher

Downstream consumer of the 64-bit LFSR generator's serial keystream. Packs the keystream bits into bytes in a small FIFO and XORs each queued key byte with one plaintext byte per valid/ready handshake, producing ciphertext bytes. Runs on the system clock. The generator's divided-clock keystream arrives as a one-cycle `i_ks_valid` strobe qualifying `i_ks_bit`.

## Interface
- `KS_FIFO_DEPTH`, default 4: key-byte FIFO entries; must be a power of 2 and ≥ 2.
- `i_clk`, input, 1: system clock; all logic on its rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_ks_bit`, input, 1: keystream bit from the generator.
- `i_ks_valid`, input, 1: qualifies `i_ks_bit` for exactly one cycle.
- `i_resync`, input, 1: one-cycle pulse, asserted after the generator is reseeded; flushes all keystream state.
- `i_data`, input, 8: plaintext byte.
- `i_data_valid`, input, 1: plaintext valid.
- `o_data_ready`, output, 1: plaintext accepted when high together with `i_data_valid`.
- `o_data`, output, 8: ciphertext byte.
- `o_data_valid`, output, 1: ciphertext valid.
- `i_data_ready`, input, 1: sink ready.
- `o_ks_level`, output, `$clog2(KS_FIFO_DEPTH)+1`: key bytes queued.
- `o_ks_overflow`, output, 1: sticky flag; a completed key byte was dropped.

## Operation
**Packer**
- 7-bit shift register plus 3-bit bit counter.
- On `i_ks_valid`: `sr <= {sr[5:0], i_ks_bit}` and the counter increments. Bits are packed MSB-first; the first bit received becomes byte bit 7.
- When the counter is 7 and `i_ks_valid` is high, the byte `{sr, i_ks_bit}` is complete. The counter wraps to 0.
- A completed byte is pushed into the FIFO if there is space after this cycle's pop. Otherwise it is dropped and `o_ks_overflow` is set.
- The keystream has no backpressure; bits are never stalled.

**FIFO**
- Depth `KS_FIFO_DEPTH`, with wrapping read and write pointers.
- Push and pop in the same cycle are both honoured, including when the FIFO is full; the level is then unchanged.
- A byte pushed into an empty FIFO becomes poppable on the next cycle. There is no bypass path.

**Cipher stage**
- `o_data_ready = !i_resync && (level != 0) && (!o_data_valid || i_data_ready)`. This is combinational from registered state, `i_resync` and `i_data_ready`.
- On a plaintext handshake (`i_data_valid && o_data_ready`):
  - pop the FIFO head;
  - `o_data <= i_data ^ head`;
  - `o_data_valid <= 1`.
- Otherwise, if `i_data_ready` is high, `o_data_valid <= 0`. `o_data` holds its last value.
- While `o_data_valid && !i_data_ready`, `o_data` and `o_data_valid` are held stable.

**Resync**
- `i_resync` clears:
  - the packer counter and shift register;
  - the FIFO pointers and level;
  - `o_data_valid`;
  - `o_ks_overflow`.
- In the resync cycle, `i_ks_valid` is ignored and no plaintext is accepted.
- Priority: `i_rst` > `i_resync` > normal operation.

**Reset values**
- `o_data` = 0x00, `o_data_valid` = 0, `o_data_ready` = 0, `o_ks_level` = 0, `o_ks_overflow` = 0.
- Packer counter = 0, shift register = 0.

## Timing
- Plaintext handshake in cycle N: ciphertext is valid in cycle N+1.
- Sustained throughput is one byte per cycle while key bytes are available and the sink is ready.
- 8th keystream strobe in cycle N: `o_ks_level` increments in cycle N+1, and `o_data_ready` can be high from N+1.
- `o_ks_overflow` rises in the cycle after the dropped byte completes. It is cleared only by `i_rst` or `i_resync`.
- Reset or resync mid-byte discards the partial byte. The next 8 strobes form a fresh byte.

## Structure
- Shared package `keystream_pkg`:
  - `BYTE_W = 8`;
  - typedef `ks_byte_t` (logic [7:0]);
  - localparam for the level width derived from the depth.
- Sub-module `keystream_byte_fifo`: synchronous FIFO with push, pop, flush, full, empty and level; flush is driven by `i_resync`.
- The packer and cipher stage live in the top module.

## Test plan
- **Basic encrypt:** after reset, strobe bits 1,0,1,1,0,0,1,0 (key 0xB2) one per 8 cycles, then plaintext 0x41 with the sink ready. Expect `o_data` = 0xF3 one cycle after the handshake, and `o_ks_level` going 1 → 0.
- **Overflow:** strobe 40 bits of bytes 0x01..0x05 with no plaintext. Expect `o_ks_level` = 4 and `o_ks_overflow` = 1. Four plaintext 0x00 bytes then return 0x01, 0x02, 0x03, 0x04; 0x05 is lost.
- **Backpressure:** key bytes queued, `i_data_ready` = 0. The first ciphertext holds stable, `o_data_ready` drops, and no key byte is popped until the sink is ready.
- **Full push and pop:** FIFO full, 8th strobe in the same cycle as a plaintext handshake. Expect level to stay at 4, no overflow, and the byte order preserved.
- **Resync mid-byte:** 5 strobes, pulse `i_resync`, then 8 strobes of 1s. Expect level 1 with head 0xFF, `o_ks_overflow` = 0, and plaintext 0x0F → 0xF0.
- **Reset mid-stream:** `i_rst` while `o_data_valid` = 1 and level = 3. Next cycle, all outputs are at their reset values.
